kbd_text_writer: RTL
====================

KBD_TEXT_WRITER -- requirements
Module: kbd_text_writer

Interface
REQ-001 SHALL have parameter COLS, default 80, text columns per row.
REQ-002 SHALL have parameter ROWS, default 30, text rows.
REQ-003 SHALL have parameter ADDR_W, default 12, character-RAM address width; COLS*ROWS <= 2^ADDR_W.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port fifo_notempty  input  1  keycode FIFO holds at least one byte (registered in FIFO).
REQ-007 SHALL have port fifo_pop  output  1  pop request to keycode FIFO.
REQ-008 SHALL have port fifo_data  input  8  FIFO read data, valid the cycle after the pop cycle.
REQ-009 SHALL have port wr_en  output  1  character-RAM write strobe.
REQ-010 SHALL have port wr_addr  output  ADDR_W  write address = row*COLS + col.
REQ-011 SHALL have port wr_data  output  8  character code written.
REQ-012 SHALL have port cur_col  output  7  current cursor column, 0..COLS-1.
REQ-013 SHALL have port cur_row  output  5  current cursor row, 0..ROWS-1.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, POP, CAPTURE, WRITE, CLEAR; all outputs registered.
REQ-016 IDLE: fifo_notempty=1 -> POP; else stay.
REQ-017 POP: fifo_pop=1 for exactly one cycle -> CAPTURE; fifo_pop=0 in every other state.
REQ-018 CAPTURE: latch fifo_data into internal byte register -> WRITE.
REQ-019 WRITE, byte 0x20..0x7E: wr_en=1, wr_addr=cursor address, wr_data=byte; then cursor advances one column.
REQ-020 WRITE, byte 0x0D or 0x0A: no write; cur_col<=0, row advances.
REQ-021 WRITE, byte 0x08: if cur_col>0, cur_col<=cur_col-1 and wr_en=1, wr_data=0x20 at the decremented address; if cur_col=0, no write, no cursor change.
REQ-022 WRITE, any other byte: discarded, no write, no cursor change.
REQ-023 Column advance at cur_col=COLS-1 SHALL set cur_col<=0 and advance row.
REQ-024 Row advance at cur_row=ROWS-1 SHALL wrap cur_row<=0.
REQ-025 After WRITE, next state is CLEAR if a row advance occurred and the feature of REQ-033 is compiled in; otherwise IDLE.
REQ-026 Printable byte timing: pop at cycle T, wr_en at T+2, updated cursor visible T+3, IDLE at T+3.
REQ-027 No second pop SHALL occur within 2 cycles of a previous pop, so the FIFO's registered notempty is current.
REQ-028 wr_addr SHALL be computed at ADDR_W bits with no truncation for all legal row/col.
REQ-029 No pop SHALL be issued in CLEAR; bytes remain queued in the FIFO.

Reset
REQ-030 resetn=0 at a clock edge SHALL force IDLE, fifo_pop=0, wr_en=0, wr_addr=0, wr_data=0, cur_col=0, cur_row=0, busy=0, byte register=0.
REQ-031 Reset asserted mid-POP, CAPTURE, WRITE or CLEAR SHALL abort with no further write; the in-flight popped byte is lost.
REQ-032 Reset SHALL NOT clear character RAM.

Configuration
REQ-033 Macro VGAMINIKBD_ROW_CLEAR_EN defined: on every row advance, CLEAR writes 0x20 to all COLS cells of the new row, one per cycle, columns 0..COLS-1 ascending (COLS cycles, wr_en continuous), then IDLE.
REQ-034 Macro VGAMINIKBD_ROW_CLEAR_EN undefined: CLEAR state unreachable, new rows keep previous contents, row advance costs no extra cycles.

Verification
REQ-035 Reset, FIFO supplies 0x41 -> one pop; wr_en two cycles later with wr_addr=0, wr_data=0x41; cursor (0,1) after.
REQ-036 Cursor at col 79 row 2, byte 0x5A -> write addr 239 data 0x5A; cursor (row 3, col 0); with macro, 80 writes of 0x20 at addr 240..319.
REQ-037 Cursor row 29 col 5, byte 0x0D -> no char write; cursor (0,0); with macro, 0x20 written at addr 0..79.
REQ-038 Cursor col 0 row 4, byte 0x08 -> no write, cursor unchanged; then at col 3, 0x08 -> write 0x20 at addr 322, cur_col=2.
REQ-039 FIFO holds 0x07,0x42 -> 0x07 discarded, 0x42 written at cursor; fifo_pop pulses exactly twice, each one cycle wide.
REQ-040 resetn low during CLEAR at column 40 -> wr_en low next cycle, cursor (0,0), IDLE, no pop until resetn high.

Source files
------------

// File: rtl/kbd_text_writer.sv
// Drains keycode bytes from a FIFO and writes printable characters into a
// character RAM, tracking a text cursor. Optional feature: VGAMINIKBD_ROW_CLEAR_EN.
module kbd_text_writer #(
   parameter int COLS   = 80,
   parameter int ROWS   = 30,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              fifo_notempty,
   output logic              fifo_pop,
   input  logic [7:0]        fifo_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [6:0]        cur_col,
   output logic [4:0]        cur_row,
   output logic              busy,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_POP     = 3'd1,
      S_CAPTURE = 3'd2,
      S_WRITE   = 3'd3,
      S_CLEAR   = 3'd4
   } state_t;

`ifdef VGAMINIKBD_ROW_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   state_t            state, state_n;
   logic [7:0]        byte_reg, byte_n;
   logic [6:0]        clr_col, clr_n;
   logic [6:0]        col_n;
   logic [4:0]        row_n;
   logic              row_adv;
   logic              fifo_pop_n, wr_en_n, busy_n;
   logic [ADDR_W-1:0] wr_addr_n;
   logic [7:0]        wr_data_n;

   function automatic logic [ADDR_W-1:0] addr_of(input logic [4:0] r, input logic [6:0] c);
      return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
   endfunction

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= 8'h20) && (b <= 8'h7E);
   endfunction

   // Valid/ready: fifo_notempty acts as valid, the one-cycle fifo_pop pulse as
   // ready; data is taken the cycle after the pop. Leaving CAPTURE and WRITE
   // always passes through IDLE, so notempty is re-sampled after each pop.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= S_IDLE;
         byte_reg <= 8'h00;
         clr_col  <= 7'd0;
         fifo_pop <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= 8'h00;
         cur_col  <= 7'd0;
         cur_row  <= 5'd0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         byte_reg <= byte_n;
         clr_col  <= clr_n;
         fifo_pop <= fifo_pop_n;
         wr_en    <= wr_en_n;
         wr_addr  <= wr_addr_n;
         wr_data  <= wr_data_n;
         cur_col  <= col_n;
         cur_row  <= row_n;
         busy     <= busy_n;
      end
   end

   always_comb begin
      state_n = state;
      row_adv = 1'b0;
      case (state)
         S_IDLE:    if (fifo_notempty) state_n = S_POP;
         S_POP:     state_n = S_CAPTURE;
         S_CAPTURE: state_n = S_WRITE;
         S_WRITE: begin
            if (is_printable(byte_reg))
               row_adv = (cur_col == 7'(COLS-1));
            else if (byte_reg == 8'h0D || byte_reg == 8'h0A)
               row_adv = 1'b1;
            state_n = (row_adv && CLEAR_EN) ? S_CLEAR : S_IDLE;
         end
         S_CLEAR:   if (clr_col == 7'(COLS-1)) state_n = S_IDLE;
         default:   state_n = S_IDLE;
      endcase
   end

   // Next values of every registered output; the write strobe for a byte is
   // decided from fifo_data in CAPTURE so it appears in the WRITE cycle.
   always_comb begin
      fifo_pop_n = (state_n == S_POP);
      busy_n     = (state_n != S_IDLE);
      wr_en_n    = 1'b0;
      wr_addr_n  = wr_addr;
      wr_data_n  = wr_data;
      byte_n     = byte_reg;
      clr_n      = clr_col;
      col_n      = cur_col;
      row_n      = cur_row;
      case (state)
         S_CAPTURE: begin
            byte_n = fifo_data;
            if (is_printable(fifo_data)) begin
               wr_en_n   = 1'b1;
               wr_addr_n = addr_of(cur_row, cur_col);
               wr_data_n = fifo_data;
            end else if (fifo_data == 8'h08 && cur_col != 7'd0) begin
               wr_en_n   = 1'b1;
               wr_addr_n = addr_of(cur_row, cur_col - 7'd1);
               wr_data_n = 8'h20;
            end
         end
         S_WRITE: begin
            if (row_adv)
               col_n = 7'd0;
            else if (is_printable(byte_reg))
               col_n = cur_col + 7'd1;
            else if (byte_reg == 8'h08 && cur_col != 7'd0)
               col_n = cur_col - 7'd1;
            if (row_adv)
               row_n = (cur_row == 5'(ROWS-1)) ? 5'd0 : cur_row + 5'd1;
            if (state_n == S_CLEAR) begin
               wr_en_n   = 1'b1;
               wr_addr_n = addr_of(row_n, 7'd0);
               wr_data_n = 8'h20;
               clr_n     = 7'd0;
            end
         end
         S_CLEAR: begin
            if (clr_col != 7'(COLS-1)) begin
               wr_en_n   = 1'b1;
               wr_addr_n = addr_of(cur_row, clr_col + 7'd1);
               wr_data_n = 8'h20;
               clr_n     = clr_col + 7'd1;
            end
         end
         default: ;
      endcase
   end

   assign state_dbg = state;

endmodule
